// File: rtl/sdram_init_rfsh_ctrl_pkg.sv
// sdram_init_rfsh_ctrl_pkg: command encodings, FSM state codes and mode-word helpers
package sdram_init_rfsh_ctrl_pkg;
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_AR  = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;
    localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;
    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_INIT_WAIT   = 4'd1;
    localparam logic [3:0] S_PRE         = 4'd2;
    localparam logic [3:0] S_PRE_WAIT    = 4'd3;
    localparam logic [3:0] S_AR1         = 4'd4;
    localparam logic [3:0] S_AR1_WAIT    = 4'd5;
    localparam logic [3:0] S_AR2         = 4'd6;
    localparam logic [3:0] S_AR2_WAIT    = 4'd7;
    localparam logic [3:0] S_LMR         = 4'd8;
    localparam logic [3:0] S_LMR_WAIT    = 4'd9;
    localparam logic [3:0] S_READY       = 4'd10;
    localparam logic [3:0] S_RF_PRE      = 4'd11;
    localparam logic [3:0] S_RF_PRE_WAIT = 4'd12;
    localparam logic [3:0] S_RF_AR       = 4'd13;
    localparam logic [3:0] S_RF_AR_WAIT  = 4'd14;

    function automatic logic cas_legal(input logic [2:0] cas);
        return cas == 3'b010 || cas == 3'b011;
    endfunction

    function automatic logic [12:0] mode_word(input logic [2:0] cas, input logic [2:0] bl);
        return {3'b000, 1'b0, 2'b00, cas, 1'b0, bl};
    endfunction
endpackage

// File: rtl/sdram_init_rfsh_ctrl_timer.sv
// sdram_init_rfsh_ctrl_timer: refresh period counter, saturating pending count, sticky overrun
module sdram_init_rfsh_ctrl_timer #(
    parameter int RFSH_PERIOD = 256,
    parameter int RFMAX       = 4
) (
    input  logic sdram_clk,
    input  logic sdram_rst,
    input  logic run,
    input  logic dec,
    output logic pend,
    output logic overrun
);
    localparam int PW = $clog2(RFSH_PERIOD);
    localparam int NW = $clog2(RFMAX + 1);
    logic [PW-1:0] per;
    logic [NW-1:0] num;
    logic expire;
    assign expire = run && per == PW'(RFSH_PERIOD - 1);
    assign pend = num != '0;
    // free-running period counter while the controller is READY or refreshing
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) per <= '0;
        else per <= (!run || expire) ? '0 : per + 1'b1;
    end
    // pending refreshes: expiry adds, refresh issue removes, both together cancel out
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) num <= '0;
        else if (!run) num <= '0;
        else if (expire && !dec && num != NW'(RFMAX)) num <= num + 1'b1;
        else if (dec && !expire) num <= num - 1'b1;
    end
    // overrun latches when an expiry finds the pending count already full
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) overrun <= 1'b0;
        else if (expire && !dec && num == NW'(RFMAX)) overrun <= 1'b1;
    end
endmodule

// File: rtl/sdram_init_rfsh_ctrl.sv
// sdram_init_rfsh_ctrl: SDRAM power-up init sequencer and periodic auto-refresh command generator
module sdram_init_rfsh_ctrl
    import sdram_init_rfsh_ctrl_pkg::*;
#(
    parameter int INIT_WAIT   = 10000,
    parameter int CMD_HOLD    = 2,
    parameter int TRP_D       = 4,
    parameter int TRCAR_D     = 7,
    parameter int RFSH_PERIOD = 256,
    parameter int RFMAX       = 4
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        sdram_en,
    input  logic [2:0]  cfg_cas,
    input  logic [2:0]  cfg_bl,
    input  logic        rfsh_gnt,
    output logic        rfsh_req,
    output logic        bus_own,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_ba,
    output logic        init_done,
    output logic        cas_err,
    output logic        rfsh_overrun
);
    localparam int CW = $clog2(INIT_WAIT + 1);
    logic [3:0] st, nxt;
    logic [CW-1:0] cnt, len;
    logic [2:0] cmd_nxt;
    logic [12:0] addr_nxt;
    logic en_q, pend, run, dec, done;
    assign done = cnt == len - 1'b1;
    assign run = sdram_en && st >= S_READY;
    assign dec = st == S_RF_PRE_WAIT && nxt == S_RF_AR;
    assign sdram_ba = 2'b00;

    sdram_init_rfsh_ctrl_timer #(.RFSH_PERIOD(RFSH_PERIOD), .RFMAX(RFMAX)) u_timer (
        .sdram_clk(sdram_clk),
        .sdram_rst(sdram_rst),
        .run(run),
        .dec(dec),
        .pend(pend),
        .overrun(rfsh_overrun)
    );

    // dwell time of each timed state; IDLE and READY wait on events instead
    always_comb begin
        len = '0;
        case (st)
            S_INIT_WAIT: len = CW'(INIT_WAIT);
            S_PRE, S_AR1, S_AR2, S_LMR, S_RF_PRE, S_RF_AR: len = CW'(CMD_HOLD);
            S_PRE_WAIT, S_LMR_WAIT, S_RF_PRE_WAIT: len = CW'(TRP_D);
            S_AR1_WAIT, S_AR2_WAIT, S_RF_AR_WAIT: len = CW'(TRCAR_D);
            default: len = '0;
        endcase
    end

    // states are numbered in sequence order, so timed states simply step to the next code
    always_comb begin
        nxt = st;
        case (st)
            S_IDLE: if (!en_q) nxt = S_INIT_WAIT;
            S_READY: if (rfsh_gnt && pend) nxt = S_RF_PRE;
            S_LMR_WAIT, S_RF_AR_WAIT: if (done) nxt = S_READY;
            default: if (done) nxt = st + 4'd1;
        endcase
        if (!sdram_en) nxt = S_IDLE;
    end

    // command and address driven for the current state; disable forces NOP at once
    always_comb begin
        cmd_nxt = CMD_NOP;
        addr_nxt = '0;
        case (st)
            S_PRE, S_RF_PRE: begin
                cmd_nxt = CMD_PRE;
                addr_nxt = PRE_ALL_ADDR;
            end
            S_AR1, S_AR2, S_RF_AR: cmd_nxt = CMD_AR;
            S_LMR: begin
                cmd_nxt = CMD_LMR;
                addr_nxt = mode_word(cas_legal(cfg_cas) ? cfg_cas : 3'b011, cfg_bl);
            end
            default: ;
        endcase
        if (!sdram_en) begin
            cmd_nxt = CMD_NOP;
            addr_nxt = '0;
        end
    end

    // state, dwell counter and enable history for rising-edge detection
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            st <= S_IDLE;
            cnt <= '0;
            en_q <= 1'b0;
        end else begin
            st <= nxt;
            cnt <= (nxt != st || len == '0) ? '0 : cnt + 1'b1;
            en_q <= sdram_en;
        end
    end

    // registered pin and status outputs, one cycle behind the state
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            {sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
            sdram_addr <= '0;
            bus_own <= 1'b0;
            init_done <= 1'b0;
            rfsh_req <= 1'b0;
            cas_err <= 1'b0;
        end else begin
            {sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_nxt;
            sdram_addr <= addr_nxt;
            bus_own <= sdram_en && st >= S_INIT_WAIT && st != S_READY;
            init_done <= sdram_en && st >= S_READY;
            rfsh_req <= sdram_en && st == S_READY && pend && !rfsh_gnt;
            cas_err <= sdram_en && st == S_LMR && cnt == '0 && !cas_legal(cfg_cas);
        end
    end
endmodule
